// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table, FSM states and the x/y/z vector type
// for the iterative Q8.24 CORDIC rotator.
package cordic_pkg;

  localparam int ITER = 24;

  localparam logic signed [31:0] K    = 32'sh009B74EE;
  localparam logic signed [31:0] PI_2 = 32'sh01921FB5;
  localparam logic signed [31:0] PI_4 = 32'sh00C90FDB;

  // round(atan(2^-i) * 2^24)
  localparam logic signed [31:0] atan_tab [ITER] = '{
    32'sh00C90FDB, 32'sh0076B19C, 32'sh003EB6EC, 32'sh001FD5BB,
    32'sh000FFAAE, 32'sh0007FF55, 32'sh0003FFEB, 32'sh0001FFFD,
    32'sh00010000, 32'sh00008000, 32'sh00004000, 32'sh00002000,
    32'sh00001000, 32'sh00000800, 32'sh00000400, 32'sh00000200,
    32'sh00000100, 32'sh00000080, 32'sh00000040, 32'sh00000020,
    32'sh00000010, 32'sh00000008, 32'sh00000004, 32'sh00000002
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ITER, ST_DONE} state_t;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vec_t;

endpackage

// File: rtl/cordic_stage.sv
// One combinational rotation-mode micro-rotation: (x, y, z, i) -> next (x, y, z).
module cordic_stage
  import cordic_pkg::*;
(
  input  vec_t       cur,
  input  logic [4:0] idx,
  output vec_t       nxt
);

  logic signed [31:0] xs, ys, at;

  always_comb begin
    xs = $signed(cur.x) >>> idx;
    ys = $signed(cur.y) >>> idx;
    at = (idx < 5'(ITER)) ? atan_tab[idx] : '0;
    if (cur.z[31]) begin
      nxt.x = cur.x + ys;
      nxt.y = cur.y - xs;
      nxt.z = cur.z + at;
    end else begin
      nxt.x = cur.x - ys;
      nxt.y = cur.y + xs;
      nxt.z = cur.z - at;
    end
  end

endmodule

// File: rtl/cordic.sv
// Iterative CORDIC rotator: one conversion per reset release, cos/sin of ang_i
// in Q8.24, ready held high from completion until the next reset.
module cordic
  import cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic signed [31:0] ang_i,
  output logic               ready,
  output logic signed [31:0] cos_o,
  output logic signed [31:0] sin_o
);

  state_t     state, nxt_state;
  vec_t       cur, step;
  logic [4:0] i;
  logic       iter_left;

  assign iter_left = (i < 5'(ITER));

  cordic_stage u_stage (
    .cur (cur),
    .idx (i),
    .nxt (step)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   state <= ST_IDLE;
    else if (en) state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: nxt_state = ST_LOAD;
      ST_LOAD: nxt_state = ST_ITER;
      ST_ITER: if (!iter_left) nxt_state = ST_DONE;
      ST_DONE: nxt_state = ST_DONE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // LOAD holds freshly loaded operands, so it already performs iteration 0;
  // this keeps the edge count at load + 24 rotations + done = 26.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur   <= '0;
      i     <= '0;
      ready <= 1'b0;
      cos_o <= '0;
      sin_o <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          cur.x <= K;
          cur.y <= '0;
          cur.z <= ang_i;
          i     <= '0;
        end
        ST_LOAD, ST_ITER: begin
          if (iter_left) begin
            cur <= step;
            i   <= i + 5'd1;
          end else begin
            cos_o <= cur.x;
            sin_o <= cur.y;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic.sv
// Directed bench for cordic: ideal trig model with LSB tolerance, exact
// latency/ready tracking from counted enabled edges, and hand literals.
module tb_cordic;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               en = 1'b0;
  logic signed [31:0] ang_i = '0;
  logic               ready;
  logic signed [31:0] cos_o, sin_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .ang_i (ang_i),
    .ready (ready),
    .cos_o (cos_o),
    .sin_o (sin_o)
  );

  // Model: count enabled edges since release; the first one captures the angle.
  int                 edges = 0;
  logic signed [31:0] m_ang = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edges <= 0;
      m_ang <= '0;
    end else if (en) begin
      if (edges == 0) m_ang <= ang_i;
      if (edges < 1000) edges <= edges + 1;
    end
  end

  function automatic real ideal(input logic signed [31:0] a, input bit want_sin);
    real r;
    r = $itor(a) / 16777216.0;
    return (want_sin ? $sin(r) : $cos(r)) * 16777216.0;
  endfunction

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input longint act, input real exp, input real tol);
    real d;
    d = $itor(act) - exp;
    if (d < 0.0) d = -d;
    chk(nm, d <= tol, act, longint'($rtoi(exp)));
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_ready", ready == 1'b0, longint'(ready), 0);
      chk("rst_cos", cos_o == 0, longint'(cos_o), 0);
      chk("rst_sin", sin_o == 0, longint'(sin_o), 0);
    end else begin
      chk("ready", ready == (edges >= 26), longint'(ready), longint'(edges >= 26));
      if (edges >= 26) begin
        chk_near("cos_model", longint'(cos_o), ideal(m_ang, 1'b0), 64.0);
        chk_near("sin_model", longint'(sin_o), ideal(m_ang, 1'b1), 64.0);
      end
    end
  end

  // One conversion; optional en gap after gap_at edges, optional mid-run
  // ang_i change after chg_at edges (must be ignored).
  task automatic run(input string nm, input logic signed [31:0] a,
                     input int gap_at, input int gap_len, input int chg_at,
                     input int exp_lat, input logic signed [31:0] lit_c,
                     input logic signed [31:0] lit_s);
    int n;
    @(posedge clk); #2;
    rstn  = 1'b0;
    ang_i = a;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
      if (gap_len > 0 && n == gap_at) en = 1'b0;
      if (gap_len > 0 && n == gap_at + gap_len) en = 1'b1;
      if (chg_at > 0 && n == chg_at) ang_i = ~a;
    end while (!ready && n < 200);
    chk({nm, "_latency"}, n == exp_lat, n, exp_lat);
    chk_near({nm, "_cos_lit"}, longint'(cos_o), $itor(lit_c), 64.0);
    chk_near({nm, "_sin_lit"}, longint'(sin_o), $itor(lit_s), 64.0);
    chk_near({nm, "_model_cos_lit"}, longint'(lit_c), ideal(a, 1'b0), 2.0);
    chk_near({nm, "_model_sin_lit"}, longint'(lit_s), ideal(a, 1'b1), 2.0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);

    run("deg30",   32'sh00860A91, 0, 0, 0, 26, 32'sh00DDB3D7, 32'sh00800000);
    run("deg90",   32'sh01921FB5, 0, 0, 0, 26, 32'sh00000000, 32'sh01000000);
    run("deg0",    32'sh00000000, 0, 0, 5, 26, 32'sh01000000, 32'sh00000000);
    run("deg72",   32'sh0141B2F7, 0, 0, 0, 26, 32'sh004F1BBD, 32'sh00F37871);
    run("degm72", -32'sh0141B2F7, 0, 0, 0, 26, 32'sh004F1BBD, -32'sh00F37871);
    run("gap72",   32'sh0141B2F7, 8, 10, 0, 36, 32'sh004F1BBD, 32'sh00F37871);

    // Abort around iteration 12, switch angle while held in reset.
    @(posedge clk); #2;
    rstn  = 1'b0;
    ang_i = 32'sh0141B2F7;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (14) @(posedge clk);
    #2 rstn = 1'b0;
    ang_i = 32'sh00860A91;
    chk("abort_ready", ready == 1'b0, longint'(ready), 0);
    chk("abort_cos", cos_o == 0, longint'(cos_o), 0);
    chk("abort_sin", sin_o == 0, longint'(sin_o), 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!ready && n < 200);
    chk("abort_latency", n == 26, n, 26);
    chk_near("abort_cos_lit", longint'(cos_o), $itor(32'sh00DDB3D7), 64.0);
    chk_near("abort_sin_lit", longint'(sin_o), $itor(32'sh00800000), 64.0);
    en = 1'b0;
    repeat (5) @(posedge clk);
    en = 1'b1;
    repeat (20) @(posedge clk);
    #2 chk("ready_held", ready == 1'b1, longint'(ready), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
